// File: rtl/fft_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_scheduler
// Purpose  : Sequences an in-place radix-2 DIT FFT over the shared sample RAM.
//            After a start pulse it issues a bit-reverse swap pass followed by
//            log2(N) butterfly stages, each op being a pair of RAM addresses
//            plus a twiddle index, over a valid/ready handshake. A barrier
//            between passes holds off the next pass until every issued op has
//            been written back, and a one-cycle done pulse ends the run.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          clock
//   i_rstn         asynchronous active-low reset
//   i_DATA_LOADED  start pulse (honoured only in IDLE)
//   i_LOG2_N       log2 of the sample count, sampled on start (1..ADDR_WIDTH)
//   o_BF_VALID     op request valid
//   i_BF_READY     datapath accepts the presented op
//   o_OP           0 = butterfly, 1 = swap
//   o_ADDR_A       first RAM index
//   o_ADDR_B       second RAM index
//   o_TW_INDEX     twiddle ROM index (0 for swaps)
//   i_BF_DONE      one previously accepted op has been written back
//   o_BUSY         high in every state except IDLE
//   o_CALC_END     one-cycle pulse when the transform is complete
//   o_CFG_ERR      one-cycle pulse when a start is rejected (bad i_LOG2_N)
// ============================================================================
module fft_stage_scheduler #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_DATA_LOADED,
  input  logic [3:0]            i_LOG2_N,
  output logic                  o_BF_VALID,
  input  logic                  i_BF_READY,
  output logic                  o_OP,
  output logic [ADDR_WIDTH-1:0] o_ADDR_A,
  output logic [ADDR_WIDTH-1:0] o_ADDR_B,
  output logic [ADDR_WIDTH-2:0] o_TW_INDEX,
  input  logic                  i_BF_DONE,
  output logic                  o_BUSY,
  output logic                  o_CALC_END,
  output logic                  o_CFG_ERR
);

  localparam logic [3:0]            MAX_OS  = 4'(MAX_OUTSTANDING);
  localparam logic [3:0]            L_MAX   = 4'(ADDR_WIDTH);
  localparam logic [4:0]            AW5     = 5'(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BITREV   = 3'd1,
    BR_DRAIN = 3'd2,
    COMPUTE  = 3'd3,
    ST_DRAIN = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              log2_n, log2_n_nxt;
  logic [ADDR_WIDTH-1:0]   scan_i, scan_i_nxt;
  logic [ADDR_WIDTH-1:0]   bf_k, bf_k_nxt;
  logic [3:0]              stage, stage_nxt;
  logic [3:0]              outstanding;

  logic                    bf_valid;
  logic                    op_swap;
  logic                    cfg_err;
  logic                    xfer;
  logic                    done_eff;
  logic                    drain_ok;
  logic                    can_issue;
  logic                    start_ok;

  logic [ADDR_WIDTH-1:0]   last_index;
  logic [ADDR_WIDTH-1:0]   last_k;
  logic [ADDR_WIDTH-1:0]   rev_full;
  logic [ADDR_WIDTH-1:0]   rev_i;
  logic                    swap_needed;

  logic [ADDR_WIDTH-1:0]   half;
  logic [ADDR_WIDTH-1:0]   bf_j;
  logic [ADDR_WIDTH-1:0]   bf_g;
  logic [4:0]              stage_p1;
  logic [3:0]              tw_shift;
  logic [ADDR_WIDTH-1:0]   bf_addr_a;
  logic [ADDR_WIDTH-1:0]   bf_addr_b;
  logic [ADDR_WIDTH-2:0]   bf_tw;

  // --------------------------------------------------------------------------
  // Index arithmetic
  // --------------------------------------------------------------------------
  // N-1 as an all-ones mask of L bits; L == ADDR_WIDTH shifts everything out
  // and yields all ones, so N = 2^ADDR_WIDTH needs no extra bit.
  assign last_index = ~({ADDR_WIDTH{1'b1}} << log2_n);
  assign last_k     = last_index >> 1;

  // Reverse all ADDR_WIDTH bits, then drop the unused low bits so the result
  // is the reversal over exactly L bits.
  for (genvar b = 0; b < ADDR_WIDTH; b++) begin : g_rev
    assign rev_full[b] = scan_i[ADDR_WIDTH-1-b];
  end
  assign rev_i       = rev_full >> (AW5 - {1'b0, log2_n});
  assign swap_needed = (scan_i < rev_i);

  // Butterfly k of stage s: A = (g << (s+1)) | j, B = A + half. Bit s of A is
  // always zero, so the add reduces to an OR.
  assign half      = IDX_ONE << stage;
  assign bf_j      = bf_k & (half - IDX_ONE);
  assign bf_g      = bf_k >> stage;
  assign stage_p1  = {1'b0, stage} + 5'd1;
  assign bf_addr_a = (bf_g << stage_p1) | bf_j;
  assign bf_addr_b = bf_addr_a | half;
  // j < 2^s <= 2^(ADDR_WIDTH-1), so j always fits the twiddle width.
  assign tw_shift  = log2_n - 4'd1 - stage;
  assign bf_tw     = bf_j[ADDR_WIDTH-2:0] << tw_shift;

  // --------------------------------------------------------------------------
  // Handshake and outstanding tracking
  // --------------------------------------------------------------------------
  assign can_issue = (outstanding < MAX_OS);
  assign xfer      = bf_valid && i_BF_READY;
  assign done_eff  = i_BF_DONE && (outstanding != 4'd0);
  // Drain states never issue, so the count after this edge is zero when it is
  // already zero or the last pending op completes right now.
  assign drain_ok  = (outstanding == 4'd0) ||
                     ((outstanding == 4'd1) && i_BF_DONE);
  assign start_ok  = (i_LOG2_N != 4'd0) && (i_LOG2_N <= L_MAX);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      outstanding <= 4'd0;
    end else if (xfer && !done_eff) begin
      outstanding <= outstanding + 4'd1;
    end else if (!xfer && done_eff) begin
      outstanding <= outstanding - 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      log2_n <= 4'd0;
      scan_i <= '0;
      bf_k   <= '0;
      stage  <= 4'd0;
    end else begin
      state  <= state_nxt;
      log2_n <= log2_n_nxt;
      scan_i <= scan_i_nxt;
      bf_k   <= bf_k_nxt;
      stage  <= stage_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and request logic. Counters advance only on a transfer, so the
  // presented op is stable while valid is held against a low ready; valid
  // itself cannot drop because the count only rises on a transfer.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    log2_n_nxt = log2_n;
    scan_i_nxt = scan_i;
    bf_k_nxt   = bf_k;
    stage_nxt  = stage;
    bf_valid   = 1'b0;
    op_swap    = 1'b0;
    cfg_err    = 1'b0;

    case (state)
      IDLE: begin
        if (i_DATA_LOADED) begin
          if (start_ok) begin
            log2_n_nxt = i_LOG2_N;
            scan_i_nxt = '0;
            bf_k_nxt   = '0;
            stage_nxt  = 4'd0;
            state_nxt  = BITREV;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end

      BITREV: begin
        if (swap_needed) begin
          bf_valid = can_issue;
          op_swap  = 1'b1;
          if (can_issue && i_BF_READY) begin
            scan_i_nxt = scan_i + IDX_ONE;
            if (scan_i == last_index) state_nxt = BR_DRAIN;
          end
        end else begin
          // Self-mapped or already-swapped index: skip without a request.
          scan_i_nxt = scan_i + IDX_ONE;
          if (scan_i == last_index) state_nxt = BR_DRAIN;
        end
      end

      BR_DRAIN: begin
        if (drain_ok) begin
          stage_nxt = 4'd0;
          bf_k_nxt  = '0;
          state_nxt = COMPUTE;
        end
      end

      COMPUTE: begin
        bf_valid = can_issue;
        if (can_issue && i_BF_READY) begin
          bf_k_nxt = bf_k + IDX_ONE;
          if (bf_k == last_k) state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (drain_ok) begin
          if (stage < (log2_n - 4'd1)) begin
            stage_nxt = stage + 4'd1;
            bf_k_nxt  = '0;
            state_nxt = COMPUTE;
          end else begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: op fields are driven to zero whenever no request is presented.
  // --------------------------------------------------------------------------
  always_comb begin
    o_OP       = 1'b0;
    o_ADDR_A   = '0;
    o_ADDR_B   = '0;
    o_TW_INDEX = '0;
    if (bf_valid) begin
      if (op_swap) begin
        o_OP     = 1'b1;
        o_ADDR_A = scan_i;
        o_ADDR_B = rev_i;
      end else begin
        o_ADDR_A   = bf_addr_a;
        o_ADDR_B   = bf_addr_b;
        o_TW_INDEX = bf_tw;
      end
    end
  end

  assign o_BF_VALID = bf_valid;
  assign o_BUSY     = (state != IDLE);
  assign o_CALC_END = (state == DONE);
  assign o_CFG_ERR  = cfg_err;

endmodule
`default_nettype wire
